// File: rtl/sysbus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sysbus_pkg
// Description : Shared types and constants for the system-bus initiator:
//               FSM state encoding, response error codes, access-size
//               encodings and the command legality check.
// Revision    : 1.0 - initial release
// ============================================================================
package sysbus_pkg;

  // Architectural data/address width of the bus.
  localparam int c_xlen = 32;

  // Initiator FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARB    = 3'd1,
    ST_ACCESS = 3'd2,
    ST_RDATA  = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  // Response error codes reported on rsp_error.
  localparam logic [2:0] c_err_ok       = 3'd0;
  localparam logic [2:0] c_err_nohit    = 3'd2;
  localparam logic [2:0] c_err_misalign = 3'd3;
  localparam logic [2:0] c_err_badsize  = 3'd4;

  // Access sizes as log2 of the byte count.
  localparam logic [2:0] c_size_byte = 3'd0;
  localparam logic [2:0] c_size_half = 3'd1;
  localparam logic [2:0] c_size_word = 3'd2;

  // Classify a command before any bus activity: an unsupported size wins
  // over misalignment, and a legal command reports c_err_ok.
  function automatic logic [2:0] f_check_cmd(
    input logic [2:0] size,
    input logic [1:0] addr_lo,
    input logic [2:0] max_size
  );
    if ((size > max_size) || (size > c_size_word)) begin
      return c_err_badsize;
    end
    if ((size == c_size_half) && addr_lo[0]) begin
      return c_err_misalign;
    end
    if ((size == c_size_word) && (addr_lo != 2'b00)) begin
      return c_err_misalign;
    end
    return c_err_ok;
  endfunction

endpackage : sysbus_pkg
`default_nettype wire

// File: rtl/sysbus_lane_steer.sv
`default_nettype none
// ============================================================================
// Module      : sysbus_lane_steer
// Description : Combinational byte-lane steering for a 32-bit bus: byte
//               enable generation, write-data replication across lanes and
//               read-data extraction (shift down + zero-extend).
// Revision    : 1.0 - initial release
// ============================================================================
module sysbus_lane_steer
  import sysbus_pkg::*;
(
  input  logic [1:0]        i_addr_lo,
  input  logic [2:0]        i_size,
  input  logic [c_xlen-1:0] i_wdata,
  input  logic [c_xlen-1:0] i_rdata_raw,
  output logic [3:0]        o_byte_en,
  output logic [c_xlen-1:0] o_wdata_lanes,
  output logic [c_xlen-1:0] o_rdata
);

  logic [c_xlen-1:0] w_rdata_shifted;

  // Enabled lanes start at the addressed byte and span the access width.
  always_comb begin
    o_byte_en = 4'b0000;
    case (i_size)
      c_size_byte: o_byte_en = 4'b0001 << i_addr_lo;
      c_size_half: o_byte_en = 4'b0011 << i_addr_lo;
      default:     o_byte_en = 4'b1111 << i_addr_lo;
    endcase
  end

  // Replicate narrow write data on every lane so the responder can pick any.
  always_comb begin
    o_wdata_lanes = i_wdata;
    case (i_size)
      c_size_byte: o_wdata_lanes = {4{i_wdata[7:0]}};
      c_size_half: o_wdata_lanes = {2{i_wdata[15:0]}};
      default:     o_wdata_lanes = i_wdata;
    endcase
  end

  // Bring the addressed lane down to bit 0 and clear bits above the size.
  always_comb begin
    w_rdata_shifted = i_rdata_raw >> {i_addr_lo, 3'b000};
    o_rdata         = w_rdata_shifted;
    case (i_size)
      c_size_byte: o_rdata = {24'd0, w_rdata_shifted[7:0]};
      c_size_half: o_rdata = {16'd0, w_rdata_shifted[15:0]};
      default:     o_rdata = w_rdata_shifted;
    endcase
  end

endmodule : sysbus_lane_steer
`default_nettype wire

// File: rtl/sysbus_initiator.sv
`default_nettype none
// ============================================================================
// Module      : sysbus_initiator
// Description : Single-outstanding system-bus initiator. Accepts a command,
//               validates size/alignment, arbitrates for the bus, performs a
//               one-cycle access, collects read data and returns a one-cycle
//               response with error code and post-command address.
// Revision    : 1.0 - initial release
// ============================================================================
module sysbus_initiator
  import sysbus_pkg::*;
#(
  parameter int MaxSize = 2
)
(
  input  logic              clk,
  input  logic              rst_n,
  // Command channel
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [c_xlen-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [c_xlen-1:0] cmd_wdata,
  input  logic              cmd_autoinc,
  // Response channel
  output logic              rsp_valid,
  output logic [c_xlen-1:0] rsp_rdata,
  output logic [2:0]        rsp_error,
  output logic [c_xlen-1:0] next_addr,
  output logic              busy,
  // Arbitration
  output logic              bus_req,
  input  logic              bus_grant,
  // Shared bus, initiator side (driven only during the access cycle)
  output wire  [c_xlen-3:0] bus_address,
  output wire  [3:0]        bus_byte_enable,
  output wire  [c_xlen-1:0] bus_data_ctp,
  output wire               bus_read,
  output wire               bus_write,
  input  logic              bus_hit,
  input  logic [c_xlen-1:0] bus_data_ptc
);

  localparam logic [2:0] c_max_size = MaxSize[2:0];

  // Latched command and response registers
  state_t            r_state;
  logic              r_write;
  logic [c_xlen-1:0] r_addr;
  logic [2:0]        r_size;
  logic [c_xlen-1:0] r_wdata;
  logic              r_autoinc;
  logic              r_bus_req;
  logic              r_rsp_valid;
  logic [c_xlen-1:0] r_rsp_rdata;
  logic [2:0]        r_rsp_error;
  logic [c_xlen-1:0] r_next_addr;

  logic [2:0]        w_cmd_err;
  logic              w_drive;
  logic [3:0]        w_byte_en;
  logic [c_xlen-1:0] w_wdata_lanes;
  logic [c_xlen-1:0] w_rdata;
  logic [c_xlen-1:0] w_incr;
  logic [c_xlen-1:0] w_next_ok;

  // Legality of the command currently offered on the command channel.
  assign w_cmd_err = f_check_cmd(cmd_size, cmd_addr[1:0], c_max_size);

  // Address reported after a successful command; wraps modulo 2^XLEN.
  assign w_incr    = {{(c_xlen-1){1'b0}}, 1'b1} << r_size;
  assign w_next_ok = r_autoinc ? (r_addr + w_incr) : r_addr;

  sysbus_lane_steer u_lane_steer (
    .i_addr_lo     (r_addr[1:0]),
    .i_size        (r_size),
    .i_wdata       (r_wdata),
    .i_rdata_raw   (bus_data_ptc),
    .o_byte_en     (w_byte_en),
    .o_wdata_lanes (w_wdata_lanes),
    .o_rdata       (w_rdata)
  );

  // Command sequencing: validate, arbitrate, access, collect, respond.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_size      <= 3'd0;
      r_wdata     <= '0;
      r_autoinc   <= 1'b0;
      r_bus_req   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_error <= c_err_ok;
      r_next_addr <= '0;
    end else begin
      // The response strobe is a single-cycle pulse unless re-armed below.
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_write   <= cmd_write;
            r_addr    <= cmd_addr;
            r_size    <= cmd_size;
            r_wdata   <= cmd_wdata;
            r_autoinc <= cmd_autoinc;
            if (w_cmd_err != c_err_ok) begin
              // Illegal command: answer without touching the bus.
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_error <= w_cmd_err;
              r_rsp_rdata <= '0;
              r_next_addr <= cmd_addr;
            end else begin
              r_state   <= ST_ARB;
              r_bus_req <= 1'b1;
            end
          end
        end
        ST_ARB: begin
          if (bus_grant) begin
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!bus_hit) begin
            r_state     <= ST_RESP;
            r_bus_req   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_error <= c_err_nohit;
            r_rsp_rdata <= '0;
            r_next_addr <= r_addr;
          end else if (r_write) begin
            r_state     <= ST_RESP;
            r_bus_req   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_error <= c_err_ok;
            r_rsp_rdata <= '0;
            r_next_addr <= w_next_ok;
          end else begin
            // Read data arrives from the responder one cycle later.
            r_state <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          r_state     <= ST_RESP;
          r_bus_req   <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_rsp_error <= c_err_ok;
          r_rsp_rdata <= w_rdata;
          r_next_addr <= w_next_ok;
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Bus pins are owned only during the single access cycle; otherwise they
  // float so other initiators can drive the shared bus.
  assign w_drive         = (r_state == ST_ACCESS);
  assign bus_address     = w_drive ? r_addr[c_xlen-1:2] : {(c_xlen-2){1'bz}};
  assign bus_byte_enable = w_drive ? w_byte_en          : 4'bzzzz;
  assign bus_data_ctp    = w_drive ? w_wdata_lanes      : {c_xlen{1'bz}};
  assign bus_read        = w_drive ? ~r_write           : 1'bz;
  assign bus_write       = w_drive ?  r_write           : 1'bz;

  // Status and response outputs come straight from state/registers.
  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign bus_req   = r_bus_req;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_error = r_rsp_error;
  assign next_addr = r_next_addr;

endmodule : sysbus_initiator
`default_nettype wire

// File: tb/tb_sysbus_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_sysbus_initiator
// Description : Self-checking bench for sysbus_initiator: directed vector
//               table, reset-during-read sequence and randomized commands
//               checked against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sysbus_initiator;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        autoinc;
    logic        hit;
    logic [31:0] rdata;
    int          delay;
  } cmd_t;

  typedef struct {
    logic [2:0]  err;
    logic [31:0] rdata;
    logic [31:0] nxt;
    logic [3:0]  be;
    logic [31:0] ctp;
    int          lat;
    int          nacc;
    int          reqc;
  } exp_t;

  typedef struct {
    cmd_t c;
    exp_t e;
  } vec_t;

  typedef struct {
    int          lat;
    int          nacc;
    int          acc_cyc;
    int          reqc;
    int          busy_gap;
    logic [3:0]  be;
    logic [31:0] ctp;
    logic [29:0] baddr;
    logic        both;
    logic        ready0;
    logic        after_ok;
    logic        timeout;
    logic [2:0]  err;
    logic [31:0] rdata;
    logic [31:0] nxt;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [2:0]  cmd_size = '0;
  logic [31:0] cmd_wdata = '0;
  logic        cmd_autoinc = 1'b0;
  logic        bus_grant = 1'b0;
  logic        tb_hit = 1'b0;
  logic [31:0] tb_rdata = '0;
  logic        prev_read = 1'b0;

  logic        cmd_ready, rsp_valid, busy, bus_req, bus_hit;
  logic [31:0] rsp_rdata, next_addr, bus_data_ptc;
  logic [2:0]  rsp_error;
  wire  [29:0] bus_address;
  wire  [3:0]  bus_byte_enable;
  wire  [31:0] bus_data_ctp;
  wire         bus_read, bus_write;

  int total = 0;
  int bad   = 0;

  sysbus_initiator #(.MaxSize(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_write       (cmd_write),
    .cmd_addr        (cmd_addr),
    .cmd_size        (cmd_size),
    .cmd_wdata       (cmd_wdata),
    .cmd_autoinc     (cmd_autoinc),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .rsp_error       (rsp_error),
    .next_addr       (next_addr),
    .busy            (busy),
    .bus_req         (bus_req),
    .bus_grant       (bus_grant),
    .bus_address     (bus_address),
    .bus_byte_enable (bus_byte_enable),
    .bus_data_ctp    (bus_data_ctp),
    .bus_read        (bus_read),
    .bus_write       (bus_write),
    .bus_hit         (bus_hit),
    .bus_data_ptc    (bus_data_ptc)
  );

  always #5 clk = ~clk;

  // Responder: read data is valid only in the cycle after a read access.
  always @(posedge clk) prev_read <= (bus_read === 1'b1);
  assign bus_hit      = tb_hit;
  assign bus_data_ptc = prev_read ? tb_rdata : 32'hBAD0_BAD0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Behavioural reference: outcome of one command from the access rules.
  function automatic exp_t model(input cmd_t c);
    exp_t e;
    int nbytes;
    longint unsigned mask;
    e = '{default:0};
    nbytes = 1;
    if (c.size > 3'd2) e.err = 3'd4;
    else begin
      nbytes = 1 << c.size;
      if ((c.addr % nbytes) != 0) e.err = 3'd3;
      else if (!c.hit)            e.err = 3'd2;
    end
    if (e.err == 3'd0 || e.err == 3'd2) begin
      e.nacc = 1;
      e.be   = 4'(((1 << nbytes) - 1) << (c.addr % 4));
      case (c.size)
        3'd0:    e.ctp = 32'(c.wdata[7:0])  * 32'h0101_0101;
        3'd1:    e.ctp = 32'(c.wdata[15:0]) * 32'h0001_0001;
        default: e.ctp = c.wdata;
      endcase
      e.lat  = c.delay + ((e.err == 3'd0 && !c.write) ? 4 : 3);
      e.reqc = e.lat - 1;
    end else begin
      e.lat = 1;
    end
    if (e.err == 3'd0 && !c.write) begin
      mask    = (64'd1 << (8 * nbytes)) - 64'd1;
      e.rdata = 32'((64'(c.rdata) >> (8 * (c.addr % 4))) & mask);
    end
    e.nxt = (e.err == 3'd0 && c.autoinc) ? c.addr + 32'(nbytes) : c.addr;
    return e;
  endfunction

  // Issue one command and record everything seen until the response.
  task automatic run_cmd(input cmd_t c, output obs_t o);
    int  cyc;
    bit  done;
    o = '{default:0};
    @(negedge clk);
    o.ready0    = cmd_ready;
    cmd_valid   = 1'b1;
    cmd_write   = c.write;
    cmd_addr    = c.addr;
    cmd_size    = c.size;
    cmd_wdata   = c.wdata;
    cmd_autoinc = c.autoinc;
    tb_hit      = c.hit;
    tb_rdata    = c.rdata;
    bus_grant   = 1'b0;
    cyc  = 0;
    done = 0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      cmd_valid = 1'b0;
      if (bus_read === 1'b1 || bus_write === 1'b1) begin
        o.nacc++;
        o.acc_cyc = cyc;
        o.be      = bus_byte_enable;
        o.ctp     = bus_data_ctp;
        o.baddr   = bus_address;
        if (bus_read === 1'b1 && bus_write === 1'b1) o.both = 1'b1;
      end
      if (bus_req === 1'b1) o.reqc++;
      if (busy !== 1'b1 || cmd_ready !== 1'b0) o.busy_gap++;
      if (rsp_valid === 1'b1) begin
        done    = 1;
        o.lat   = cyc;
        o.err   = rsp_error;
        o.rdata = rsp_rdata;
        o.nxt   = next_addr;
      end
      bus_grant = (cyc > c.delay);
    end
    bus_grant = 1'b0;
    o.timeout = !done;
    @(negedge clk);
    o.after_ok = (rsp_valid === 1'b0) && (busy === 1'b0) && (cmd_ready === 1'b1);
  endtask

  task automatic check_txn(input string tag, input cmd_t c, input exp_t e, input obs_t o);
    check({tag, " timeout"}, 32'(o.timeout), 32'd0);
    check({tag, " ready"},   32'(o.ready0), 32'd1);
    check({tag, " err"},     32'(o.err), 32'(e.err));
    check({tag, " rdata"},   o.rdata, e.rdata);
    check({tag, " next"},    o.nxt, e.nxt);
    check({tag, " lat"},     32'(o.lat), 32'(e.lat));
    check({tag, " nacc"},    32'(o.nacc), 32'(e.nacc));
    check({tag, " reqc"},    32'(o.reqc), 32'(e.reqc));
    check({tag, " busy"},    32'(o.busy_gap), 32'd0);
    check({tag, " rw_both"}, 32'(o.both), 32'd0);
    check({tag, " after"},   32'(o.after_ok), 32'd1);
    if (e.nacc == 1 && o.nacc == 1) begin
      check({tag, " be"},     32'(o.be), 32'(e.be));
      check({tag, " baddr"},  32'(o.baddr), 32'(c.addr[31:2]));
      check({tag, " acccyc"}, 32'(o.acc_cyc), 32'(c.delay + 2));
      if (c.write) check({tag, " ctp"}, o.ctp, e.ctp);
    end
  endtask

  function automatic vec_t mk(
    input logic w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] wd,
    input logic ai, input logic h, input logic [31:0] rd, input int d,
    input logic [2:0] xe, input logic [31:0] xr, input logic [31:0] xn,
    input logic [3:0] xb, input logic [31:0] xc, input int xl);
    vec_t v;
    v.c = '{write:w, addr:a, size:s, wdata:wd, autoinc:ai, hit:h, rdata:rd, delay:d};
    v.e.err   = xe;
    v.e.rdata = xr;
    v.e.nxt   = xn;
    v.e.be    = xb;
    v.e.ctp   = xc;
    v.e.lat   = xl;
    v.e.nacc  = (xe == 3'd0 || xe == 3'd2) ? 1 : 0;
    v.e.reqc  = (v.e.nacc == 1) ? xl - 1 : 0;
    return v;
  endfunction

  initial begin
    vec_t vt[11];
    cmd_t c;
    exp_t e;
    obs_t o;
    int   n_rsp;

    #500000;
    $display("FAIL watchdog: got no-finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vt[11];
    cmd_t c;
    exp_t e;
    obs_t o;
    int   n_rsp;

    //         w  addr          sz  wdata         ai h  rdata         d  err rdata         next          be       ctp           lat
    vt[0]  = mk(1, 32'h0000_1000, 2, 32'hDEAD_BEEF, 0, 1, 32'h0,        0, 0, 32'h0,        32'h0000_1000, 4'b1111, 32'hDEAD_BEEF, 3);
    vt[1]  = mk(0, 32'h0000_1003, 0, 32'h0,        0, 1, 32'h1122_3344, 0, 0, 32'h0000_0011, 32'h0000_1003, 4'b1000, 32'h0,        4);
    vt[2]  = mk(0, 32'h0000_1001, 1, 32'h0,        0, 1, 32'h1122_3344, 0, 3, 32'h0,        32'h0000_1001, 4'b0000, 32'h0,        1);
    vt[3]  = mk(1, 32'h0000_2000, 2, 32'h1234_5678, 1, 0, 32'h0,        1, 2, 32'h0,        32'h0000_2000, 4'b1111, 32'h1234_5678, 4);
    vt[4]  = mk(0, 32'hFFFF_FFFC, 2, 32'h0,        1, 1, 32'hCAFE_F00D, 5, 0, 32'hCAFE_F00D, 32'h0000_0000, 4'b1111, 32'h0,        9);
    vt[5]  = mk(0, 32'h0000_0000, 3, 32'h0,        1, 1, 32'h0,        0, 4, 32'h0,        32'h0000_0000, 4'b0000, 32'h0,        1);
    vt[6]  = mk(1, 32'h0000_1002, 1, 32'h0000_ABCD, 1, 1, 32'h0,        0, 0, 32'h0,        32'h0000_1004, 4'b1100, 32'hABCD_ABCD, 3);
    vt[7]  = mk(1, 32'h0000_3001, 0, 32'hFFFF_FF5A, 1, 1, 32'h0,        2, 0, 32'h0,        32'h0000_3002, 4'b0010, 32'h5A5A_5A5A, 5);
    vt[8]  = mk(0, 32'h0000_1002, 1, 32'h0,        1, 1, 32'h1122_3344, 0, 0, 32'h0000_1122, 32'h0000_1004, 4'b1100, 32'h0,        4);
    vt[9]  = mk(1, 32'h0000_1002, 2, 32'h0,        1, 1, 32'h0,        0, 3, 32'h0,        32'h0000_1002, 4'b0000, 32'h0,        1);
    vt[10] = mk(0, 32'h0000_2001, 0, 32'h0,        1, 0, 32'h5566_7788, 0, 2, 32'h0,        32'h0000_2001, 4'b0010, 32'h0,        3);

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst busy",      32'(busy), 32'd0);
    check("rst bus_req",   32'(bus_req), 32'd0);
    check("rst rsp_rdata", rsp_rdata, 32'd0);
    check("rst rsp_error", 32'(rsp_error), 32'd0);
    check("rst next_addr", next_addr, 32'd0);
    check("rst read",      32'(bus_read === 1'b1), 32'd0);
    check("rst write",     32'(bus_write === 1'b1), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle ready", 32'(cmd_ready), 32'd1);

    // Directed vector table
    for (int i = 0; i < 11; i++) begin
      run_cmd(vt[i].c, o);
      check_txn($sformatf("vec%0d", i), vt[i].c, vt[i].e, o);
    end

    // Reset while the read data is being collected
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0040; cmd_size = 3'd2;
    cmd_autoinc = 1'b1; tb_hit = 1'b1; tb_rdata = 32'h0BAD_F00D; bus_grant = 1'b1;
    @(negedge clk); cmd_valid = 1'b0;   // ARB
    @(negedge clk);                     // ACCESS
    check("midrst access", 32'(bus_read === 1'b1), 32'd1);
    @(negedge clk);                     // RDATA
    check("midrst pre busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst busy",      32'(busy), 32'd0);
    check("midrst bus_req",   32'(bus_req), 32'd0);
    check("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst next_addr", next_addr, 32'd0);
    check("midrst rsp_rdata", rsp_rdata, 32'd0);
    check("midrst rsp_error", 32'(rsp_error), 32'd0);
    bus_grant = 1'b0;
    n_rsp = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) n_rsp++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) n_rsp++;
    end
    check("midrst no rsp", 32'(n_rsp), 32'd0);
    run_cmd(vt[0].c, o);
    check_txn("postrst", vt[0].c, vt[0].e, o);

    // Randomized commands against the model
    for (int i = 0; i < 80; i++) begin
      c.write   = 1'($urandom_range(0, 1));
      c.size    = ($urandom_range(0, 9) == 0) ? 3'(3 + $urandom_range(0, 4)) : 3'($urandom_range(0, 2));
      c.addr    = $urandom;
      if ($urandom_range(0, 3) != 0 && c.size <= 3'd2) c.addr = c.addr & ~((32'd1 << c.size) - 32'd1);
      c.wdata   = $urandom;
      c.autoinc = 1'($urandom_range(0, 1));
      c.hit     = ($urandom_range(0, 3) != 0);
      c.rdata   = $urandom;
      c.delay   = int'($urandom_range(0, 3));
      if (i == 5) c.addr = 32'hFFFF_FFFC;
      e = model(c);
      run_cmd(c, o);
      check_txn($sformatf("rnd%0d", i), c, e, o);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sysbus_initiator
`default_nettype wire
